seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
Programmable serial bit-sequence detector. It is the parametrised successor to our fixed 4-bit Moore detector.
- Pattern, length and overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe.
- Includes a saturating match counter.
- Sits on a serial input lane; z feeds the interrupt/trigger logic and match_cnt is read by status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (LSB-aligned).
- DEF_LEN, 4, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  x is a valid serial bit this cycle.
- x  in  1  serial data bit.
- cfg_we  in  1  load pattern_in/len_in/overlap_in.
- pattern_in  in  MAX_LEN  pattern, LSB-aligned; bit len-1 is the first bit received.
- len_in  in  $clog2(MAX_LEN+1)  pattern length.
- overlap_in  in  1  1 = overlapping matches allowed.
- clr_cnt  in  1  clear match_cnt.
- z  out  1  Moore match flag.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0 at a clock edge):
  - z=0, match_cnt=0, history=0, fill=0.
  - Config registers load DEF_PATTERN/DEF_LEN/DEF_OVERLAP.
  - Reset overrides every other input.
- State:
  - history: MAX_LEN-bit shift register; on accept, history <= {history[MAX_LEN-2:0], x}.
  - fill: count of bits accepted since the last reset, config load or non-overlap match; saturates at MAX_LEN.
- Accept: a bit is accepted when en=1 && cfg_we=0. While en=0, all state holds, including z.
- Match condition, evaluated on the next-state values at an accept edge:
  - fill_next >= L, and
  - history_next[L-1:0] == pattern[L-1:0].
- Effective length L:
  - len 0: detector disabled; z never asserts.
  - len > MAX_LEN: clamped to MAX_LEN.
- Moore output z is a register:
  - Set to 1 at the edge where the completing bit is accepted, so z is visible the cycle after that bit is presented.
  - Stays 1 until the next accepted bit, cfg_we or reset.
  - With en=1 every cycle, z is a one-cycle pulse.
- Overlap mode:
  - Overlap=1: on a match, fill continues; suffix bits can start the next match.
  - Overlap=0: on a match, fill_next is forced to 0, so the next match needs L fresh bits.
- cfg_we=1:
  - Latches the pattern, clamped length and overlap mode.
  - Clears history, fill and z.
  - A simultaneous en/x is discarded.
  - match_cnt is unaffected.
- match_cnt:
  - +1 per match, saturating at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 forces 0. On simultaneous clr_cnt and match, clear wins: result 0, that match is not counted, but z still sets.
- Latency: bit-in to z = 1 clock; bit-in to match_cnt update = 1 clock.
- Changing pattern_in/len_in/overlap_in without cfg_we has no effect.

Decomposition:
- Package seq_detect_pkg:
  - Default constants: DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
  - Length-width localparam.
  - Length-clamp function.
- Sub-module sat_counter (CNT_W; inc, clr, cnt, clear priority) holds match_cnt. It is reusable by other status blocks.
- The core holds config, history, fill and z.

Test Plan:
- Default config (1011, overlap), en=1, x=1,0,1,1,0,1,1 -> z high after bits 4 and 7 only; match_cnt=2.
- cfg_we with pattern 1011, len 4, overlap=0; same stream -> z after bit 4 only; match_cnt=1.
- Pattern 111, len 3:
  - overlap=1, stream 1,1,1,1,1 -> matches at bits 3,4,5; match_cnt=3.
  - overlap=0 -> match at bit 3 only; match_cnt=1.
- Default config, bits 1,0,1,1 with en=0 gaps of 3 cycles between bits -> z stays 1 from the edge accepting bit 4 until the next accepted bit; no extra count.
- Reset and config interrupts:
  - Bits 1,0,1, then rst=0 for one cycle, then bit 1 -> no match; z=0; config back to defaults.
  - Repeat with cfg_we instead of rst -> no match; match_cnt retained.
- Counter edges:
  - CNT_W=2, 5 default matches -> match_cnt saturates at 3.
  - clr_cnt on the same edge as a match -> match_cnt=0 and z=1.
  - len_in=0 -> no match on any stream.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
//   DEF_MAX_LEN / DEF_PATTERN / DEF_LEN / DEF_OVERLAP : power-on configuration
//   len_width() : bits needed to hold a length 0..max_len
//   clamp_len() : limits a requested length to max_len
package seq_detect_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011;
  localparam int unsigned DEF_LEN = 4;
  localparam logic DEF_OVERLAP = 1'b1;

  // Width of a length/fill field able to represent 0..max_len inclusive.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Lengths above the history depth cannot be checked, so saturate them.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Serial-lane bundle for seq_detect_prog.
//   master: drives en, x, cfg_we, pattern_in, len_in, overlap_in, clr_cnt;
//           observes z, match_cnt
//   slave : the detector side (opposite directions)
interface seq_detect_prog_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = 8
);

  localparam int unsigned LEN_W = len_width(MAX_LEN);

  logic               en;
  logic               x;
  logic               cfg_we;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap_in;
  logic               clr_cnt;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output en, x, cfg_we, pattern_in, len_in, overlap_in, clr_cnt,
    input  z, match_cnt
  );

  modport slave (
    input  en, x, cfg_we, pattern_in, len_in, overlap_in, clr_cnt,
    output z, match_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
//   clk, rst : clock, synchronous active-low reset
//   inc      : count one event (ignored once the counter is full)
//   clr      : force the count to zero
//   cnt      : registered count
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector with a Moore match flag and a
// saturating match counter.
//   clk, rst : clock, synchronous active-low reset
//   bus      : seq_detect_prog_if.slave
//              en/x        qualified serial bit
//              cfg_we      load pattern_in/len_in/overlap_in, flush detector
//              clr_cnt     clear match_cnt
//              z           registered match flag
//              match_cnt   saturating number of matches
module seq_detect_prog #(
  parameter int unsigned        MAX_LEN     = seq_detect_pkg::DEF_MAX_LEN,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_detect_pkg::DEF_PATTERN),
  parameter int unsigned        DEF_LEN     = seq_detect_pkg::DEF_LEN,
  parameter logic               DEF_OVERLAP = seq_detect_pkg::DEF_OVERLAP
) (
  input  logic             clk,
  input  logic             rst,
  seq_detect_prog_if.slave bus
);

  import seq_detect_pkg::*;

  localparam int unsigned      LEN_W    = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN  = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] history_q;
  logic [LEN_W-1:0]   fill_q;
  logic               z_q;

  logic               accept_c;
  logic [MAX_LEN-1:0] history_nxt;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_nxt;
  logic               mismatch_c;
  logic               match_c;

  // Next-state of the detector for an accepted bit, and the match decision on it.
  always_comb begin
    accept_c    = bus.en && !bus.cfg_we;
    history_nxt = {history_q[MAX_LEN-2:0], bus.x};
    fill_inc    = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
    mismatch_c  = 1'b0;
    // Only the low len_q bits take part; the newest bit lines up with pattern bit 0.
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_q)) begin
        mismatch_c = mismatch_c | (history_nxt[i] ^ pattern_q[i]);
      end
    end
    match_c  = (len_q != '0) && (fill_inc >= len_q) && !mismatch_c;
    // Non-overlap mode restarts the window so the next match needs fresh bits.
    fill_nxt = (match_c && !overlap_q) ? '0 : fill_inc;
  end

  // Configuration, history, fill and the Moore flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= RST_LEN;
      overlap_q <= DEF_OVERLAP;
      history_q <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
    end else if (bus.cfg_we) begin
      pattern_q <= bus.pattern_in;
      len_q     <= LEN_W'(clamp_len(32'(bus.len_in), MAX_LEN));
      overlap_q <= bus.overlap_in;
      history_q <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
    end else if (bus.en) begin
      history_q <= history_nxt;
      fill_q    <= fill_nxt;
      z_q       <= match_c;
    end
  end

  assign bus.z = z_q;

  // Match counter; a coincident clr_cnt drops the match from the count.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept_c && match_c),
    .clr (bus.clr_cnt),
    .cnt (bus.match_cnt)
  );

endmodule
